// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and flush controller for the 5-stage pipeline.
// Keeps a shadow scoreboard of the instructions in EX, MEM and WB. From it the
// block derives load-use stalls, taken-branch flushes, EX operand forwarding
// selects, the ID-stage register-file bypass and two saturating performance
// counters (stall cycles, taken-branch flushes).
//
// No handshakes here: every output is a per-cycle enable or select for the
// datapath. A stall and a taken branch in the same cycle resolve in favour
// of the flush, because the stalled instruction is on the wrong path anyway.
module pipe_hazard_ctrl #(
  parameter int REG_ADDR_W   = 5,
  parameter int BRANCH_STAGE = 3,   // 2 = branch resolves in EX, 3 = in MEM
  parameter int LOAD_USE_EN  = 1,   // 0 = software schedules around load-use
  parameter int CNT_W        = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,          // asynchronous, active low
  input  logic                  id_valid_i,
  input  logic [REG_ADDR_W-1:0] id_rs_i,
  input  logic [REG_ADDR_W-1:0] id_rt_i,
  input  logic                  id_use_rs_i,
  input  logic                  id_use_rt_i,
  input  logic [REG_ADDR_W-1:0] id_rd_i,
  input  logic                  id_wen_i,
  input  logic                  id_load_i,
  input  logic                  br_taken_i,
  output logic                  pc_write_o,
  output logic                  if_id_write_o,
  output logic                  flush_if_id_o,
  output logic                  flush_id_ex_o,
  output logic                  flush_ex_mem_o,
  output logic [1:0]            fwd_a_o,
  output logic [1:0]            fwd_b_o,
  output logic                  id_byp_rs_o,
  output logic                  id_byp_rt_o,
  output logic                  stall_o,
  output logic [CNT_W-1:0]      stall_cnt_o,
  output logic [CNT_W-1:0]      flush_cnt_o
);

  // Forwarding select encoding for the EX operand muxes.
  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Only BRANCH_STAGE = 3 has a younger instruction sitting in EX/MEM
  // that must be squashed when the branch is taken.
  localparam logic BR_IN_MEM = (BRANCH_STAGE == 3);
  localparam logic LU_ON     = (LOAD_USE_EN != 0);

  // One scoreboard slot mirrors the control fields of one pipe register.
  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic                  use_rs;
    logic                  use_rt;
    logic [REG_ADDR_W-1:0] rd;
    logic                  wen;
    logic                  load;
  } sb_entry_t;

  sb_entry_t r_ex;
  sb_entry_t r_mem;
  sb_entry_t r_wb;
  sb_entry_t w_ex_next;
  sb_entry_t w_mem_next;

  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic       w_ex_writing;
  logic       w_mem_writing;
  logic       w_wb_writing;
  logic       w_mem_fwd_ok;
  logic       w_lu_rs_hit;
  logic       w_lu_rt_hit;
  logic       w_lu_hazard;
  logic       w_stall;
  logic       w_flush_id_ex;
  logic       w_flush_ex_mem;
  logic [1:0] w_fwd_a;
  logic [1:0] w_fwd_b;

  // A slot produces a result only if it is real, writes, and targets a
  // register other than r0 (writes to r0 are discarded by the register file).
  assign w_ex_writing  = r_ex.valid  & r_ex.wen  & (r_ex.rd  != '0);
  assign w_mem_writing = r_mem.valid & r_mem.wen & (r_mem.rd != '0);
  assign w_wb_writing  = r_wb.valid  & r_wb.wen  & (r_wb.rd  != '0);

  // A load in MEM has no ALU result to forward; its data only exists in WB.
  assign w_mem_fwd_ok  = w_mem_writing & ~r_mem.load;

  // Load-use: the instruction in ID reads the destination of a load in EX.
  assign w_lu_rs_hit = id_use_rs_i & (id_rs_i == r_ex.rd);
  assign w_lu_rt_hit = id_use_rt_i & (id_rt_i == r_ex.rd);
  assign w_lu_hazard = LU_ON & id_valid_i & w_ex_writing & r_ex.load &
                       (w_lu_rs_hit | w_lu_rt_hit);

  // Taken branch overrides the stall: the enables stay on and nothing is counted.
  assign w_stall        = w_lu_hazard & ~br_taken_i;
  assign w_flush_id_ex  = br_taken_i | w_stall;
  assign w_flush_ex_mem = BR_IN_MEM & br_taken_i;

  assign stall_o        = w_stall;
  assign pc_write_o     = ~w_stall;
  assign if_id_write_o  = ~w_stall;
  assign flush_if_id_o  = br_taken_i;
  assign flush_id_ex_o  = w_flush_id_ex;
  assign flush_ex_mem_o = w_flush_ex_mem;

  // Next EX slot: capture the ID instruction unless it is squashed or absent.
  always_comb begin
    w_ex_next = '0;
    if (id_valid_i && !w_flush_id_ex) begin
      w_ex_next.valid  = 1'b1;
      w_ex_next.rs     = id_rs_i;
      w_ex_next.rt     = id_rt_i;
      w_ex_next.use_rs = id_use_rs_i;
      w_ex_next.use_rt = id_use_rt_i;
      w_ex_next.rd     = id_rd_i;
      w_ex_next.wen    = id_wen_i;
      w_ex_next.load   = id_load_i;
    end
  end

  // Next MEM slot: the EX instruction moves on unless a MEM-stage branch kills it.
  always_comb begin
    w_mem_next = r_ex;
    if (w_flush_ex_mem) begin
      w_mem_next = '0;
    end
  end

  // Scoreboard advance; reset empties every slot immediately.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_ex  <= '0;
      r_mem <= '0;
      r_wb  <= '0;
    end else begin
      r_ex  <= w_ex_next;
      r_mem <= w_mem_next;
      r_wb  <= r_mem;
    end
  end

  // EX operand selects: the younger MEM result wins over WB.
  always_comb begin
    w_fwd_a = FWD_REG;
    if (w_mem_fwd_ok && r_ex.use_rs && (r_mem.rd == r_ex.rs)) begin
      w_fwd_a = FWD_MEM;
    end else if (w_wb_writing && (r_wb.rd == r_ex.rs)) begin
      w_fwd_a = FWD_WB;
    end

    w_fwd_b = FWD_REG;
    if (w_mem_fwd_ok && r_ex.use_rt && (r_mem.rd == r_ex.rt)) begin
      w_fwd_b = FWD_MEM;
    end else if (w_wb_writing && (r_wb.rd == r_ex.rt)) begin
      w_fwd_b = FWD_WB;
    end
  end

  assign fwd_a_o = w_fwd_a;
  assign fwd_b_o = w_fwd_b;

  // The register file is read and written in the same cycle, so ID takes the
  // WB write data directly when it reads the register being written.
  assign id_byp_rs_o = w_wb_writing & id_use_rs_i & (r_wb.rd == id_rs_i);
  assign id_byp_rt_o = w_wb_writing & id_use_rt_i & (r_wb.rd == id_rt_i);

  // Saturating performance counters for stall cycles and taken-branch flushes.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != CNT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + CNT_ONE;
      end
      if (br_taken_i && (r_flush_cnt != CNT_MAX)) begin
        r_flush_cnt <= r_flush_cnt + CNT_ONE;
      end
    end
  end

  assign stall_cnt_o = r_stall_cnt;
  assign flush_cnt_o = r_flush_cnt;

  // Fields carried for completeness of the pipe-register mirror but not
  // consulted by any hazard rule.
  logic w_unused_fields;
  assign w_unused_fields = ^{r_mem.rs, r_mem.rt, r_mem.use_rs, r_mem.use_rt,
                             r_wb.rs, r_wb.rt, r_wb.use_rs, r_wb.use_rt,
                             r_wb.load};

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Parametrised hazard, forwarding and flush controller for the 5-stage pipelined CPU. It replaces the hard-tied forwarding selects, the constant `pcWrite` and the constant pipe-register resets.
Internally it keeps a shadow scoreboard of the instructions in the EX, MEM and WB stages. From that it generates:
- load-use stalls;
- branch flushes, with the resolve stage configurable;
- EX operand forwarding selects;
- ID-stage register-file bypass;
- saturating stall and flush performance counters.

Parameters:
- REG_ADDR_W, 5, register address width.
- BRANCH_STAGE, 3, stage where the branch resolves: 2 = EX, 3 = MEM. No other value is legal.
- LOAD_USE_EN, 1, 1 = detect and stall on load-use hazards; 0 = never stall (the software schedules around them).
- CNT_W, 16, width of the performance counters.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-low reset.
- id_valid_i  in  1  the ID stage holds a real instruction.
- id_rs_i  in  REG_ADDR_W  ID source register A.
- id_rt_i  in  REG_ADDR_W  ID source register B.
- id_use_rs_i  in  1  the instruction reads rs.
- id_use_rt_i  in  1  the instruction reads rt.
- id_rd_i  in  REG_ADDR_W  ID destination, after RegDst selection.
- id_wen_i  in  1  ID RegWrite.
- id_load_i  in  1  ID MemRead (load).
- br_taken_i  in  1  the branch in BRANCH_STAGE is taken.
- pc_write_o  out  1  PC enable.
- if_id_write_o  out  1  IF/ID enable.
- flush_if_id_o  out  1  clear IF/ID.
- flush_id_ex_o  out  1  force a bubble into ID/EX.
- flush_ex_mem_o  out  1  force a bubble into EX/MEM; only driven when BRANCH_STAGE = 3.
- fwd_a_o  out  2  EX operand A select: 00 = register, 01 = MEM ALU result, 10 = WB data.
- fwd_b_o  out  2  EX operand B select, same encoding.
- id_byp_rs_o  out  1  ID rs must take WB write data.
- id_byp_rt_o  out  1  ID rt must take WB write data.
- stall_o  out  1  load-use stall is active this cycle.
- stall_cnt_o  out  CNT_W  count of stall cycles.
- flush_cnt_o  out  CNT_W  count of taken-branch flushes.

Behaviour:
- Scoreboard entries:
  - EX, MEM and WB each hold {valid, rs, rt, use_rs, use_rt, rd, wen, load}.
  - Each entry is "writing" when valid & wen & (rd != 0).
- Reset (rst_i = 0, asynchronous):
  - all entries are invalid; both counters are 0;
  - the outputs therefore settle to pc_write_o = 1, if_id_write_o = 1, all flushes 0, fwd 00, bypass 0, stall_o 0;
  - reset asserted mid-operation discards in-flight state immediately.
- Load-use hazard (LOAD_USE_EN = 1):
  - condition: id_valid_i, EX entry writing & load, and (use_rs & rs == EX.rd) or (use_rt & rt == EX.rd);
  - response: stall_o = 1, pc_write_o = 0, if_id_write_o = 0, flush_id_ex_o = 1;
  - the stall lasts exactly 1 cycle, because the load then moves to MEM.
- Taken branch (br_taken_i = 1):
  - flush_if_id_o = 1 and flush_id_ex_o = 1;
  - if BRANCH_STAGE = 3, also flush_ex_mem_o = 1;
  - pc_write_o = 1.
- Stall and branch in the same cycle:
  - the flush wins: stall_o = 0, the enables stay 1, and the stall counter does not increment.
- Scoreboard advance, every rising edge:
  - WB <= MEM;
  - MEM <= EX, or a bubble if flush_ex_mem_o;
  - EX <= ID fields, or a bubble if stall_o, flush_id_ex_o or !id_valid_i.
- Forwarding, combinational, for the EX entry:
  - A = 01 if MEM is writing, not a load, and MEM.rd == EX.rs with EX.use_rs;
  - else A = 10 if WB is writing and WB.rd == EX.rs;
  - else A = 00;
  - B is derived the same way from rt;
  - MEM has priority over WB;
  - register 0 is never forwarded;
  - a MEM load matching an EX source raises no forward (it is unreachable while LOAD_USE_EN = 1).
- ID bypass:
  - id_byp_rs_o = WB writing & use_rs & (WB.rd == id_rs_i); rt likewise.
- Counters:
  - stall_cnt_o increments on every cycle with stall_o = 1;
  - flush_cnt_o increments on every cycle with br_taken_i = 1;
  - both saturate at 2^CNT_W - 1 and never wrap.

Test Plan:
- Reset is released, then add r3,r1,r2 is followed by sub r5,r3,r4 → in the cycle sub is in EX, fwd_a_o = 01 and fwd_b_o = 00.
- lw r2,0(r1) is followed by add r4,r2,r2 → stall_o = 1 for 1 cycle with pc_write_o = 0 and flush_id_ex_o = 1; the next cycle shows fwd_a_o = fwd_b_o = 10; stall_cnt_o = 1.
- A write to r0 (add r0,r1,r1) is followed by a consumer of r0 → fwd stays 00 and no stall occurs.
- With BRANCH_STAGE = 3, br_taken_i pulses while a load-use hazard is present → the three flushes are 1, stall_o = 0, pc_write_o = 1, flush_cnt_o = 1, stall_cnt_o unchanged.
- With CNT_W = 4, 20 consecutive stall cycles are forced → stall_cnt_o saturates at 15; rst_i = 0 driven mid-sequence → the counters read 0 asynchronously and all outputs return to their reset values.
- LOAD_USE_EN = 0 with the lw/add pair → stall_o stays 0, and id_byp_rs_o = 1 when WB.rd == ID rs = 7.
